// File: rtl/load_unit_if.sv
// Core-side load handshake plus data-memory read port for load_unit.
// The slave modport is the load unit's view; master is the environment's view.
interface load_unit_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        ld_err;
  logic [1:0]  ld_err_code;

  modport slave (
    input  ld_valid, ld_addr, ld_funct3, mem_gnt, mem_rvalid, mem_rdata,
    output ld_ready, mem_req, mem_addr, ld_done, ld_data, ld_err, ld_err_code
  );

  modport master (
    output ld_valid, ld_addr, ld_funct3, mem_gnt, mem_rvalid, mem_rdata,
    input  ld_ready, mem_req, mem_addr, ld_done, ld_data, ld_err, ld_err_code
  );
endinterface

// File: rtl/load_unit.sv
// Single-outstanding load unit: issues a word read, extracts and extends the
// addressed byte/halfword, and reports misalignment, illegal type or timeout.
module load_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  load_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  // Selects the addressed lane and applies sign/zero extension for the load type.
  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lane,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b010:  extract = word;
      3'b100:  extract = {24'h00_0000, b};
      3'b101:  extract = {16'h0000, h};
      default: extract = 32'h0000_0000;
    endcase
  endfunction

  // Illegal type outranks misalignment; 2'b00 means the request may go to memory.
  function automatic logic [1:0] classify(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: classify = 2'b00;
      3'b001, 3'b101: classify = a[0] ? 2'b01 : 2'b00;
      3'b010:         classify = (a != 2'b00) ? 2'b01 : 2'b00;
      default:        classify = 2'b10;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  f3_q, f3_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ld_ready_q, ld_ready_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        ld_done_q, ld_done_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        ld_err_q, ld_err_d;
  logic [1:0]  ld_err_code_q, ld_err_code_d;
  logic [1:0]  acc_code_s;
  logic [15:0] cnt_inc_s;

  // Next-state, captured request fields and completion results.
  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    f3_d          = f3_q;
    cnt_d         = cnt_q;
    mem_addr_d    = mem_addr_q;
    ld_data_d     = ld_data_q;
    ld_err_d      = ld_err_q;
    ld_err_code_d = ld_err_code_q;
    acc_code_s    = classify(bus.ld_funct3, bus.ld_addr[1:0]);
    cnt_inc_s     = cnt_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (bus.ld_valid && ld_ready_q) begin
          lane_d = bus.ld_addr[1:0];
          f3_d   = bus.ld_funct3;
          cnt_d  = 16'd0;
          if (acc_code_s != 2'b00) begin
            state_d       = S_RESP;
            ld_data_d     = 32'h0000_0000;
            ld_err_d      = 1'b1;
            ld_err_code_d = acc_code_s;
          end else begin
            state_d    = S_REQ;
            mem_addr_d = {bus.ld_addr[31:2], 2'b00};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc_s;
        if (cnt_inc_s == TIMEOUT_LIMIT) begin
          state_d       = S_RESP;
          ld_data_d     = 32'h0000_0000;
          ld_err_d      = 1'b1;
          ld_err_code_d = 2'b11;
        end else if (bus.mem_gnt) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc_s;
        // Data landing in the final budgeted cycle still counts as on time.
        if (bus.mem_rvalid) begin
          state_d       = S_RESP;
          ld_data_d     = extract(f3_q, lane_q, bus.mem_rdata);
          ld_err_d      = 1'b0;
          ld_err_code_d = 2'b00;
        end else if (cnt_inc_s == TIMEOUT_LIMIT) begin
          state_d       = S_RESP;
          ld_data_d     = 32'h0000_0000;
          ld_err_d      = 1'b1;
          ld_err_code_d = 2'b11;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ld_ready_d = (state_d == S_IDLE);
    mem_req_d  = (state_d == S_REQ);
    ld_done_d  = (state_d == S_RESP);
  end

  // State and registered outputs, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      lane_q        <= 2'b00;
      f3_q          <= 3'b000;
      cnt_q         <= 16'd0;
      ld_ready_q    <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= 32'h0000_0000;
      ld_done_q     <= 1'b0;
      ld_data_q     <= 32'h0000_0000;
      ld_err_q      <= 1'b0;
      ld_err_code_q <= 2'b00;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      f3_q          <= f3_d;
      cnt_q         <= cnt_d;
      ld_ready_q    <= ld_ready_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      ld_done_q     <= ld_done_d;
      ld_data_q     <= ld_data_d;
      ld_err_q      <= ld_err_d;
      ld_err_code_q <= ld_err_code_d;
    end
  end

  assign bus.ld_ready    = ld_ready_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.ld_done     = ld_done_q;
  assign bus.ld_data     = ld_data_q;
  assign bus.ld_err      = ld_err_q;
  assign bus.ld_err_code = ld_err_code_q;

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: drivers push expected completions, a
// negedge monitor pops and compares them whenever ld_done is seen.
module tb_load_unit;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [1:0]  code;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  int   done_a = 0;
  int   done_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea;
  exp_t eb;

  load_unit_if a_if ();
  load_unit_if b_if ();

  load_unit dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  load_unit #(.TIMEOUT_CYCLES(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ld_done pulse is matched against the head of its queue.
  initial forever begin
    @(negedge clk);
    if (a_if.ld_done === 1'b1) begin
      done_a++;
      if (q_a.size() == 0) chk("a_unexpected_done", 32'(a_if.ld_done), 32'd0);
      else begin
        ea = q_a.pop_front();
        chk("a_data", a_if.ld_data, ea.data);
        chk("a_err", 32'(a_if.ld_err), 32'(ea.err));
        chk("a_code", 32'(a_if.ld_err_code), 32'(ea.code));
        chk("a_done_cycle", 32'(cyc), 32'(ea.cyc));
      end
    end
    if (b_if.ld_done === 1'b1) begin
      done_b++;
      if (q_b.size() == 0) chk("b_unexpected_done", 32'(b_if.ld_done), 32'd0);
      else begin
        eb = q_b.pop_front();
        chk("b_data", b_if.ld_data, eb.data);
        chk("b_err", 32'(b_if.ld_err), 32'(eb.err));
        chk("b_code", 32'(b_if.ld_err_code), 32'(eb.code));
        chk("b_done_cycle", 32'(cyc), 32'(eb.cyc));
      end
    end
  end

  task automatic issue_a(input logic [2:0] f3, input logic [31:0] addr, output int t0);
    int n = 0;
    while (a_if.ld_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (a_if.ld_ready !== 1'b1) chk("a_ready_wait", 32'(a_if.ld_ready), 32'd1);
    a_if.ld_valid  = 1'b1;
    a_if.ld_addr   = addr;
    a_if.ld_funct3 = f3;
    t0 = cyc;
    tick();
    a_if.ld_valid  = 1'b0;
  endtask

  // Good load: gnt after gnt_dly stall cycles, rvalid rv_dly cycles after gnt.
  task automatic load_ok(input logic [2:0] f3, input logic [31:0] addr, input int gnt_dly,
                         input int rv_dly, input logic [31:0] rdata, input logic [31:0] maddr,
                         input logic [31:0] exp_data, output int t0, output int done_cyc);
    exp_t e;
    issue_a(f3, addr, t0);
    done_cyc = t0 + 2 + gnt_dly + rv_dly;
    e.data = exp_data; e.err = 1'b0; e.code = 2'b00; e.cyc = done_cyc;
    q_a.push_back(e);
    for (int k = 0; k < gnt_dly; k++) begin
      chk("a_mem_req_stall", 32'(a_if.mem_req), 32'd1);
      chk("a_mem_addr_stall", a_if.mem_addr, maddr);
      tick();
    end
    chk("a_mem_req", 32'(a_if.mem_req), 32'd1);
    chk("a_mem_addr", a_if.mem_addr, maddr);
    a_if.mem_gnt = 1'b1;
    tick();
    a_if.mem_gnt = 1'b0;
    chk("a_mem_req_drop", 32'(a_if.mem_req), 32'd0);
    for (int k = 1; k < rv_dly; k++) tick();
    a_if.mem_rvalid = 1'b1;
    a_if.mem_rdata  = rdata;
    tick();
    a_if.mem_rvalid = 1'b0;
    a_if.mem_rdata  = 32'hDEAD_BEEF;
  endtask

  task automatic load_err(input logic [2:0] f3, input logic [31:0] addr, input logic [1:0] code);
    exp_t e;
    int t0;
    issue_a(f3, addr, t0);
    e.data = 32'h0000_0000; e.err = 1'b1; e.code = code; e.cyc = t0 + 1;
    q_a.push_back(e);
    chk("a_err_no_mem_req", 32'(a_if.mem_req), 32'd0);
  endtask

  initial begin
    int t0, t1, d0, d1, saved;
    a_if.ld_valid = 1'b0; a_if.ld_addr = 32'h0; a_if.ld_funct3 = 3'b000;
    a_if.mem_gnt = 1'b0; a_if.mem_rvalid = 1'b0; a_if.mem_rdata = 32'h0;
    b_if.ld_valid = 1'b0; b_if.ld_addr = 32'h0; b_if.ld_funct3 = 3'b000;
    b_if.mem_gnt = 1'b0; b_if.mem_rvalid = 1'b0; b_if.mem_rdata = 32'h0;

    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(a_if.ld_ready), 32'd0);
    chk("rst_mem_req", 32'(a_if.mem_req), 32'd0);
    chk("rst_mem_addr", a_if.mem_addr, 32'h0);
    chk("rst_done", 32'(a_if.ld_done), 32'd0);
    chk("rst_data", a_if.ld_data, 32'h0);
    chk("rst_err", 32'(a_if.ld_err), 32'd0);
    chk("rst_code", 32'(a_if.ld_err_code), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", 32'(a_if.ld_ready), 32'd1);

    load_ok(3'b000, 32'h0000_1003, 0, 1, 32'h80FF_1234, 32'h0000_1000, 32'hFFFF_FF80, t0, d0);
    load_ok(3'b101, 32'h0000_2002, 0, 1, 32'hBEEF_0000, 32'h0000_2000, 32'h0000_BEEF, t0, d0);
    load_ok(3'b001, 32'h0000_2002, 0, 1, 32'hBEEF_0000, 32'h0000_2000, 32'hFFFF_BEEF, t0, d0);
    load_ok(3'b010, 32'h0000_2000, 0, 1, 32'h1234_5678, 32'h0000_2000, 32'h1234_5678, t0, d0);
    load_ok(3'b000, 32'h0000_7000, 1, 2, 32'h0000_007F, 32'h0000_7000, 32'h0000_007F, t0, d0);
    load_ok(3'b001, 32'h0000_7002, 0, 1, 32'h7FFF_0001, 32'h0000_7000, 32'h0000_7FFF, t0, d0);

    load_err(3'b010, 32'h0000_0006, 2'b01);
    repeat (3) tick();
    chk("hold_err", 32'(a_if.ld_err), 32'd1);
    chk("hold_code", 32'(a_if.ld_err_code), 32'd1);
    chk("hold_data", a_if.ld_data, 32'h0);
    chk("hold_no_done", 32'(a_if.ld_done), 32'd0);
    load_err(3'b011, 32'h0000_0001, 2'b10);
    load_err(3'b111, 32'h0000_0000, 2'b10);
    load_err(3'b110, 32'h0000_0003, 2'b10);
    load_err(3'b001, 32'h0000_6001, 2'b01);

    // Back-to-back LBU loads with stalled grant and late data.
    load_ok(3'b100, 32'h0000_5001, 2, 3, 32'h1122_8344, 32'h0000_5000, 32'h0000_0083, t0, d0);
    load_ok(3'b100, 32'h0000_5002, 2, 3, 32'hA5B6_C7D8, 32'h0000_5000, 32'h0000_00B6, t1, d1);
    chk("b2b_accept_cycle", 32'(t1), 32'(d0 + 1));
    repeat (2) tick();
    chk("hold_data_ok", a_if.ld_data, 32'h0000_00B6);
    chk("hold_err_ok", 32'(a_if.ld_err), 32'd0);

    // Reset while waiting for data; the late rvalid must be ignored.
    issue_a(3'b010, 32'h0000_3000, t0);
    a_if.mem_gnt = 1'b1;
    tick();
    a_if.mem_gnt = 1'b0;
    saved = done_a;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_if.mem_rvalid = 1'b1;
    a_if.mem_rdata  = 32'hCAFE_F00D;
    tick();
    chk("post_rst_ready", 32'(a_if.ld_ready), 32'd1);
    chk("post_rst_mem_req", 32'(a_if.mem_req), 32'd0);
    chk("post_rst_mem_addr", a_if.mem_addr, 32'h0);
    chk("post_rst_data", a_if.ld_data, 32'h0);
    chk("post_rst_err", 32'(a_if.ld_err), 32'd0);
    chk("post_rst_code", 32'(a_if.ld_err_code), 32'd0);
    tick();
    a_if.mem_rvalid = 1'b0;
    repeat (3) tick();
    chk("post_rst_no_done", 32'(done_a), 32'(saved));

    // Timeout on the 4-cycle instance with grant withheld.
    b_if.ld_valid  = 1'b1;
    b_if.ld_addr   = 32'h0000_4000;
    b_if.ld_funct3 = 3'b010;
    chk("b_ready", 32'(b_if.ld_ready), 32'd1);
    eb.data = 32'h0; eb.err = 1'b1; eb.code = 2'b11; eb.cyc = cyc + 5;
    q_b.push_back(eb);
    tick();
    b_if.ld_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("b_mem_req_held", 32'(b_if.mem_req), 32'd1);
      chk("b_mem_addr_held", b_if.mem_addr, 32'h0000_4000);
      tick();
    end
    chk("b_mem_req_off", 32'(b_if.mem_req), 32'd0);
    tick();
    b_if.mem_rvalid = 1'b1;
    b_if.mem_rdata  = 32'h5555_AAAA;
    tick();
    b_if.mem_rvalid = 1'b0;
    repeat (4) tick();
    chk("b_single_done", 32'(done_b), 32'd1);

    chk("sb_drain_a", 32'(q_a.size()), 32'd0);
    chk("sb_drain_b", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles spent in REQ+WAIT before the load aborts with a timeout error; legal range 2..65535.
REQ-002 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n  input  1: reset; synchronous, active-low.
REQ-004 Port ld_valid  input  1: core presents a load request.
REQ-005 Port ld_ready  output  1: unit accepts a request this cycle.
REQ-006 Port ld_addr  input  32: byte address of the load.
REQ-007 Port ld_funct3  input  3: load type, 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-008 Port mem_req  output  1: read request to data memory.
REQ-009 Port mem_addr  output  32: word-aligned read address.
REQ-010 Port mem_gnt  input  1: memory accepts the request.
REQ-011 Port mem_rvalid  input  1: mem_rdata valid this cycle.
REQ-012 Port mem_rdata  input  32: little-endian read word.
REQ-013 Port ld_done  output  1: one-cycle completion pulse.
REQ-014 Port ld_data  output  32: extended load result.
REQ-015 Port ld_err  output  1: completion carries an error; valid with ld_done.
REQ-016 Port ld_err_code  output  2: 00 none, 01 misaligned, 10 illegal funct3, 11 timeout.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT and RESP; ld_ready SHALL be 1 only in IDLE.
REQ-018 A request is accepted on a cycle with ld_valid=1 and ld_ready=1; ld_addr and ld_funct3 are captured on that edge.
REQ-019 On accept with funct3 in {011,110,111}, the FSM goes to RESP with err_code 10, without asserting mem_req.
REQ-020 On accept with LH/LHU and addr[0]=1, or LW and addr[1:0]!=00, the FSM goes to RESP with err_code 01, without asserting mem_req; illegal funct3 takes priority over misalignment.
REQ-021 Otherwise, on accept the FSM goes to REQ.
REQ-022 In REQ, mem_req=1 and mem_addr={addr[31:2],2'b00}, both held stable until mem_gnt=1; on gnt the FSM goes to WAIT, and mem_req=0 from the next cycle.
REQ-023 mem_rvalid SHALL be ignored in IDLE, REQ and RESP; in WAIT, rvalid=1 captures the extracted result and the FSM goes to RESP.
REQ-024 Byte extraction SHALL use lane addr[1:0]: lane 0 = rdata[7:0], lane 3 = rdata[31:24]. Halfword extraction SHALL use rdata[15:0] if addr[1]=0, else rdata[31:16].
REQ-025 LB/LH results SHALL be sign-extended to 32 bits, LBU/LHU zero-extended, and LW passed through unchanged.
REQ-026 The timeout counter SHALL clear on accept and increment each cycle in REQ or WAIT; when it reaches TIMEOUT_CYCLES, the FSM goes to RESP with err_code 11 and any later rvalid for that load is ignored.
REQ-027 RESP SHALL last exactly one cycle with ld_done=1, then return to IDLE.
REQ-028 ld_data SHALL be 0 on any error; ld_data, ld_err and ld_err_code SHALL hold their values after the done pulse until the next ld_done.
REQ-029 Minimum latency SHALL be: accept at cycle 0, REQ at cycle 1 (gnt same cycle), rvalid at cycle 2, ld_done at cycle 3. The error path gives ld_done at cycle 1.
REQ-030 Back-to-back: a new request SHALL be acceptable on the cycle after ld_done.

Reset
REQ-031 While rst_n=0 at a clock edge: state=IDLE, counter=0, and mem_req, ld_done, ld_err, ld_err_code, ld_data, mem_addr are all 0; ld_ready=0 during reset, then 1 from the first cycle after release.
REQ-032 Reset in any state SHALL abandon the in-flight load without ld_done; an rvalid arriving after reset SHALL be ignored.

Verification
REQ-033 LB addr 0x1003, rdata 0x80FF1234, immediate gnt/rvalid -> mem_addr 0x1000, ld_data 0xFFFFFF80, ld_done at cycle 3, ld_err=0.
REQ-034 LHU addr 0x2002, rdata 0xBEEF0000 -> ld_data 0x0000BEEF; LH same -> 0xFFFFBEEF; LW addr 0x2000, rdata 0x12345678 -> 0x12345678.
REQ-035 LW addr 0x0006 -> no mem_req, ld_done at cycle 1, err_code 01, ld_data 0. funct3 011 with addr 0x0001 -> err_code 10.
REQ-036 TIMEOUT_CYCLES=4, gnt held 0 -> mem_req stays high with stable mem_addr for 4 cycles, then ld_done with err_code 11; a later rvalid produces no done.
REQ-037 Request accepted, rst_n=0 during WAIT, rvalid arrives after release -> no ld_done, outputs stay 0, ld_ready=1.
REQ-038 Two back-to-back LBU loads with gnt delayed 2 cycles and rvalid 3 cycles after gnt -> two single-cycle done pulses with correct lanes; the second request is accepted on the cycle after the first ld_done.
